mul_result_collector: RTL
=========================

# mul_result_collector

Downstream companion of the 55x16 unsigned multiplier in the gain/pitch datapath. It tracks which multiplier issue slots carry real samples, captures the 71-bit product when it emerges, rounds and saturates it to an audio-width word, and buffers results in a small FIFO behind a ready/valid output. Credit-based admission on the upstream side ensures a product already in flight always has a FIFO slot.

## Interface
Parameters:
- PSIZE, 71, product width (ASIZE 55 + BSIZE 16)
- MUL_LAT, 4, multiplier latency in clocks (3 pipe regs + out reg, no input reg)
- SHIFT, 16, right shift applied to the product before rounding (≥1)
- OUT_W, 24, output sample width
- DEPTH, 8, FIFO entries (power of two, ≥ MUL_LAT)

Ports (one clock; reset is asynchronous and active-low):
- clk  in  1  system clock, shared with the multiplier
- rst_n  in  1  async active-low reset
- s_valid  in  1  source presents a/b to the multiplier this cycle
- s_ready  out  1  collector can accept an issue this cycle
- mul_p  in  PSIZE  multiplier product output
- m_data  out  OUT_W  rounded/saturated result
- m_valid  out  1  m_data valid
- m_ready  in  1  consumer accepts m_data
- sat_flag  out  1  sticky saturation indicator
- sat_clr  in  1  synchronous clear of sat_flag
- level  out  $clog2(DEPTH)+1  FIFO occupancy

## Operation
- Issue: issue = s_valid & s_ready; the multiplier ce is tied high and samples a/b every cycle; the source holds its own a/b.
- s_ready = (level + inflight) < DEPTH, combinational from registered counts.
- Valid tracker: MUL_LAT-bit shift register vsr, vsr[0] <= issue, vsr[i] <= vsr[i-1]; inflight counter +1 on issue, -1 when vsr[MUL_LAT-1]; both together leave it unchanged.
- Capture: when vsr[MUL_LAT-1]=1, mul_p holds that issue's product; compute r = (mul_p + 2^(SHIFT-1)) >> SHIFT (round half up, unsigned, PSIZE+1 bit sum), write into FIFO on the same edge.
- Saturation: if r ≥ 2^OUT_W, write all-ones (2^OUT_W-1) and set sat_flag; else write r[OUT_W-1:0].
- sat_flag: set has priority over sat_clr in the same cycle.
- FIFO: show-ahead; m_valid = (level != 0); m_data = head entry; pop on m_valid & m_ready. Push and pop in the same cycle leave level unchanged; pointers wrap modulo DEPTH.
- Invariant level + inflight ≤ DEPTH; a write never meets a full FIFO; an assertion fires if it does.
- Reset (any time, including mid-flight): vsr=0, inflight=0, level=0, pointers=0, sat_flag=0; in-flight products are discarded. Reset values: s_ready=1, m_valid=0, m_data=0, sat_flag=0, level=0.

## Timing
- Issue in cycle c: the FIFO write occurs on the edge ending cycle c+MUL_LAT, and m_valid rises in cycle c+MUL_LAT+1 if the FIFO was empty (latency MUL_LAT+1 = 5).
- Back-to-back issues sustain 1 result/cycle while m_ready=1.
- s_ready deasserts the cycle after level+inflight reaches DEPTH and reasserts the cycle after a pop drops the sum below DEPTH.
- m_data/m_valid are stable while m_valid=1 and m_ready=0.

## Configuration
- MUL_COLLECT_SAT_EN defined: saturation and sat_flag are active as described.
- Not defined: the result is truncated, writing r[OUT_W-1:0] (wraps); sat_flag is constant 0; sat_clr is ignored.

## Test plan
- Single issue: a=3, b=0x8000, mul_p=0x18000, SHIFT=16 -> r=(0x18000+0x8000)>>16=2; m_valid high exactly 5 cycles after issue, m_data=2.
- Rounding edge: mul_p=0x7FFF -> 0; mul_p=0x8000 -> 1; mul_p=0x17FFF -> 1.
- Saturation: mul_p=2^40 (r=2^24) -> m_data=0xFFFFFF and sat_flag=1; sat_clr pulse -> 0; with the macro undefined -> m_data=0, sat_flag=0.
- Backpressure: m_ready=0, s_valid=1 continuous -> exactly 8 issues accepted, s_ready low thereafter, level=8; then m_ready=1 -> 8 results in issue order, no loss or duplication.
- Throughput: 20 back-to-back issues with m_ready=1 -> 20 consecutive m_valid cycles starting cycle 5.
- Reset mid-flight: 3 issues, rst_n low 1 cycle at cycle 2 -> no m_valid afterwards, level=0, s_ready=1.

Source files
------------

// File: rtl/mul_result_collector_if.sv
// Handshake bundle between the multiplier source/consumer and mul_result_collector.
// "slave" is the collector side; "master" is the source/consumer side.
interface mul_result_collector_if #(
    parameter int PSIZE = 71,
    parameter int OUT_W = 24,
    parameter int DEPTH = 8
);
    localparam int LW = $clog2(DEPTH) + 1;

    logic             s_valid;
    logic             s_ready;
    logic [PSIZE-1:0] mul_p;
    logic [OUT_W-1:0] m_data;
    logic             m_valid;
    logic             m_ready;
    logic             sat_flag;
    logic             sat_clr;
    logic [LW-1:0]    level;

    modport master (
        output s_valid, mul_p, m_ready, sat_clr,
        input  s_ready, m_data, m_valid, sat_flag, level
    );

    modport slave (
        input  s_valid, mul_p, m_ready, sat_clr,
        output s_ready, m_data, m_valid, sat_flag, level
    );
endinterface

// File: rtl/mul_result_collector.sv
// Tracks multiplier issue slots, rounds/saturates each emerging product and buffers it in a show-ahead FIFO.
// Define MUL_COLLECT_SAT_EN to enable saturation and the sticky sat_flag; otherwise results truncate.
module mul_result_collector #(
    parameter int PSIZE   = 71,
    parameter int MUL_LAT = 4,
    parameter int SHIFT   = 16,
    parameter int OUT_W   = 24,
    parameter int DEPTH   = 8
) (
    input logic                  clk,
    input logic                  rst_n,
    mul_result_collector_if.slave bus
);
    localparam int LW = $clog2(DEPTH) + 1;
    localparam int PW = $clog2(DEPTH);
    localparam logic [LW:0]    DEPTH_SUM = (LW+1)'(DEPTH);
    localparam logic [LW-1:0]  DEPTH_LVL = LW'(DEPTH);
    localparam logic [PSIZE:0] HALF      = (PSIZE+1)'(1) << (SHIFT - 1);

    logic [MUL_LAT-1:0] vsr_q, vsr_d;
    logic [LW-1:0]      inflight_q, inflight_d;
    logic [LW-1:0]      level_q, level_d;
    logic [PW-1:0]      wrPtr_q, wrPtr_d;
    logic [PW-1:0]      rdPtr_q, rdPtr_d;
    logic [OUT_W-1:0]   mem_q [DEPTH];

    logic               sReady;
    logic               issue;
    logic               capture;
    logic               pop;
    logic [LW:0]        committed;
    logic [PSIZE:0]     roundSum;
    logic [PSIZE:0]     rounded;
    logic               overflow;
    logic [OUT_W-1:0]   writeData;
    logic               satFlag;

    // Admission counts results already owed a slot, so an in-flight product never meets a full FIFO.
    always_comb begin
        committed = {1'b0, level_q} + {1'b0, inflight_q};
        sReady    = committed < DEPTH_SUM;
        issue     = bus.s_valid & sReady;
        capture   = vsr_q[MUL_LAT-1];
        pop       = (level_q != '0) & bus.m_ready;
    end

    // Round half up on a one-bit-wider sum so an all-ones product cannot lose its carry.
    always_comb begin
        roundSum = {1'b0, bus.mul_p} + HALF;
        rounded  = roundSum >> SHIFT;
        overflow = |rounded[PSIZE:OUT_W];
    end

    always_comb begin
        vsr_d      = (vsr_q << 1) | MUL_LAT'(issue);
        inflight_d = inflight_q;
        level_d    = level_q;
        wrPtr_d    = wrPtr_q;
        rdPtr_d    = rdPtr_q;
        case ({issue, capture})
            2'b10:   inflight_d = inflight_q + LW'(1);
            2'b01:   inflight_d = inflight_q - LW'(1);
            default: inflight_d = inflight_q;
        endcase
        case ({capture, pop})
            2'b10:   level_d = level_q + LW'(1);
            2'b01:   level_d = level_q - LW'(1);
            default: level_d = level_q;
        endcase
        if (capture) begin
            wrPtr_d = wrPtr_q + PW'(1);
        end
        if (pop) begin
            rdPtr_d = rdPtr_q + PW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vsr_q      <= '0;
            inflight_q <= '0;
            level_q    <= '0;
            wrPtr_q    <= '0;
            rdPtr_q    <= '0;
        end else begin
            vsr_q      <= vsr_d;
            inflight_q <= inflight_d;
            level_q    <= level_d;
            wrPtr_q    <= wrPtr_d;
            rdPtr_q    <= rdPtr_d;
        end
    end

    // Storage is cleared on reset so m_data reads zero until the first result lands.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else if (capture) begin
            mem_q[wrPtr_q] <= writeData;
        end
    end

`ifdef MUL_COLLECT_SAT_EN
    logic satFlag_q, satFlag_d;

    // A saturating write in the same cycle as sat_clr keeps the flag set.
    always_comb begin
        writeData = overflow ? '1 : rounded[OUT_W-1:0];
        satFlag_d = satFlag_q;
        if (bus.sat_clr) begin
            satFlag_d = 1'b0;
        end
        if (capture && overflow) begin
            satFlag_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            satFlag_q <= 1'b0;
        end else begin
            satFlag_q <= satFlag_d;
        end
    end

    assign satFlag = satFlag_q;
`else
    logic unusedSatInputs;

    always_comb begin
        writeData = rounded[OUT_W-1:0];
    end

    assign unusedSatInputs = bus.sat_clr | overflow;
    assign satFlag         = 1'b0;
`endif

    assign bus.s_ready  = sReady;
    assign bus.m_valid  = (level_q != '0);
    assign bus.m_data   = mem_q[rdPtr_q];
    assign bus.level    = level_q;
    assign bus.sat_flag = satFlag;

    noWriteWhenFull: assert property (@(posedge clk) disable iff (!rst_n)
        !(capture && (level_q == DEPTH_LVL)));

endmodule
